// File: rtl/fsic_io_serdes_rx_framer.sv
// -----------------------------------------------------------------------------
// fsic_io_serdes_rx_framer
//
// Word framer behind the per-lane IO-serdes receiver. It hunts for a 32-bit
// sync word in the nibble stream (LSB nibble first). Once aligned, it packs
// eight nibbles into one 32-bit word and queues the word in a small FIFO.
// Words leave through a valid/ready handshake.
//
// Ports:
//   coreclk          - only clock, rising edge
//   axis_rst_n       - asynchronous active-low reset
//   rxen             - lane enable; low forces IDLE and flushes the FIFO
//   rxdata_in        - pCLK_RATIO-bit beat from the serdes receiver
//   rxdata_in_valid  - beat valid (level; each high cycle is one beat)
//   word_out         - head-of-FIFO word (zero while the FIFO is empty)
//   word_out_valid   - FIFO not empty
//   word_out_ready   - consumer accepts the head word
//   locked           - high while word alignment is held
//   overflow         - sticky: a completed word was dropped on a full FIFO
//
// Build option:
//   FSIC_RX_FRAMER_SYNC_FILTER_EN - when defined, a completed word in LOCKED
//   that equals pSYNC_PATTERN is a keep-alive. It is not pushed.
// -----------------------------------------------------------------------------
module fsic_io_serdes_rx_framer #(
    parameter int          pCLK_RATIO    = 4,
    parameter logic [31:0] pSYNC_PATTERN = 32'hFC5A_C3A5,
    parameter int          pFIFO_DEPTH   = 4
) (
    input  logic                  coreclk,
    input  logic                  axis_rst_n,
    input  logic                  rxen,
    input  logic [pCLK_RATIO-1:0] rxdata_in,
    input  logic                  rxdata_in_valid,
    output logic [31:0]           word_out,
    output logic                  word_out_valid,
    input  logic                  word_out_ready,
    output logic                  locked,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(pFIFO_DEPTH);
    localparam int CNT_W = $clog2(pFIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(pFIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(pFIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HUNT   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Pointer advance with an explicit wrap, so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1'b1);
        end
        return r;
    endfunction

    logic [1:0]       state_r;
    logic [31:0]      hunt_sr_r;
    logic [2:0]       nib_cnt_r;
    logic [31:0]      part_r;
    logic [31:0]      fifo_mem_r [pFIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;

    logic [31:0]      hunt_next_s;
    logic [31:0]      word_next_s;
    logic             complete_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             wr_en_s;
    logic             ovf_set_s;

    // Next-value datapath and FIFO push/pop decisions.
    always_comb begin
        hunt_next_s = {rxdata_in, hunt_sr_r[31:pCLK_RATIO]};
        word_next_s = part_r;
        word_next_s[{nib_cnt_r, 2'b00} +: 4] = rxdata_in;
        complete_s  = rxen && (state_r == ST_LOCKED) && rxdata_in_valid
                      && (nib_cnt_r == 3'd7);
`ifdef FSIC_RX_FRAMER_SYNC_FILTER_EN
        push_s      = complete_s && (word_next_s != pSYNC_PATTERN);
`else
        push_s      = complete_s;
`endif
        pop_s       = (count_r != {CNT_W{1'b0}}) && word_out_ready;
        full_s      = (count_r == CNT_FULL);
        // A pop in the same cycle frees the slot the push needs.
        wr_en_s     = push_s && (!full_s || pop_s);
        ovf_set_s   = push_s && full_s && !pop_s;
    end

    // Alignment FSM, hunt shift register and partial-word assembly.
    always_ff @(posedge coreclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_r   <= ST_IDLE;
            hunt_sr_r <= 32'h0;
            nib_cnt_r <= 3'd0;
            part_r    <= 32'h0;
        end else if (!rxen) begin
            state_r   <= ST_IDLE;
            hunt_sr_r <= 32'h0;
            nib_cnt_r <= 3'd0;
            part_r    <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    hunt_sr_r <= 32'h0;
                    nib_cnt_r <= 3'd0;
                    part_r    <= 32'h0;
                    state_r   <= ST_HUNT;
                end
                ST_HUNT: begin
                    if (rxdata_in_valid) begin
                        hunt_sr_r <= hunt_next_s;
                        if (hunt_next_s == pSYNC_PATTERN) begin
                            state_r   <= ST_LOCKED;
                            nib_cnt_r <= 3'd0;
                            part_r    <= 32'h0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (rxdata_in_valid) begin
                        // 3-bit counter wraps 7 -> 0 on word completion.
                        nib_cnt_r <= nib_cnt_r + 3'd1;
                        part_r    <= word_next_s;
                    end else begin
                        state_r   <= ST_HUNT;
                        nib_cnt_r <= 3'd0;
                        part_r    <= 32'h0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    nib_cnt_r <= 3'd0;
                    part_r    <= 32'h0;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky overflow. These are cleared whenever
    // the lane is disabled or idle.
    always_ff @(posedge coreclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (!rxen || (state_r == ST_IDLE)) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // FIFO storage. This is data only; occupancy qualifies every read.
    always_ff @(posedge coreclk) begin
        if (wr_en_s) begin
            fifo_mem_r[wr_ptr_r] <= word_next_s;
        end
    end

    // Output decode. The head word is a direct read of storage, gated to zero
    // while the FIFO is empty.
    always_comb begin
        word_out_valid = (count_r != {CNT_W{1'b0}});
        locked         = (state_r == ST_LOCKED);
        overflow       = overflow_r;
        if (word_out_valid) begin
            word_out = fifo_mem_r[rd_ptr_r];
        end else begin
            word_out = 32'h0;
        end
    end

endmodule

// File: doc/fsic_io_serdes_rx_framer.md
# fsic_io_serdes_rx_framer

Word framer directly downstream of the per-lane IO-serdes receiver, in the `coreclk` domain. Takes the receiver's `pCLK_RATIO`-bit parallel output, one nibble per `coreclk`, and hunts for a 32-bit sync word to find word alignment. Once aligned, it assembles nibbles LSB-first into 32-bit words and buffers them in a small FIFO. Words leave through a valid/ready interface toward the AXIS-side logic.

## Interface
- `pCLK_RATIO`, 4: bits per input beat; fixed to 4 in this release.
- `pSYNC_PATTERN`, 32'hFC5A_C3A5: alignment word, sent LSB nibble first.
- `pFIFO_DEPTH`, 4: output FIFO entries, 2..8.

Ports:
- `coreclk` in 1: the block's only clock; every register updates on its rising edge.
- `axis_rst_n` in 1: asynchronous, active-low reset.
- `rxen` in 1: lane enable; low forces IDLE.
- `rxdata_in` in `pCLK_RATIO`: beat from the serdes receiver.
- `rxdata_in_valid` in 1: beat valid; a level, so each high cycle is one new beat.
- `word_out` out 32: head-of-FIFO word.
- `word_out_valid` out 1: FIFO not empty.
- `word_out_ready` in 1: consumer accepts the head word.
- `locked` out 1: high in LOCKED state.
- `overflow` out 1: sticky; a word was dropped because the FIFO was full.

## Operation
- States: IDLE, HUNT, LOCKED. Reset state is IDLE.
- **IDLE**
  - Hunt shift register, nibble counter, partial word and FIFO are cleared, and `overflow` is cleared.
  - Moves to HUNT when `rxen`=1.
- **HUNT**
  - On each valid beat: `hunt_sr <= {rxdata_in, hunt_sr[31:4]}`.
  - If the next value of `hunt_sr` equals `pSYNC_PATTERN`, go to LOCKED with nibble count 0.
  - The sync word itself is never pushed into the FIFO.
  - Beats with `rxdata_in_valid`=0 are ignored.
- **LOCKED**
  - Each valid beat goes to bits [4k+3:4k] of the partial word, where k is the nibble count 0..7.
  - At k=7 the word is complete; it goes to the FIFO push path and k wraps to 0.
  - If `rxdata_in_valid`=0 in any cycle, the partial word is discarded and the state returns to HUNT. FIFO contents are kept.
- **`rxen`=0** from any state goes to IDLE the next edge. This flushes the FIFO and drops `word_out_valid`.
- **Push when full**
  - The word is dropped and `overflow` is set to 1.
  - If a pop happens in the same cycle, the push is accepted and no overflow occurs.
- **Pop**: occurs when `word_out_valid` && `word_out_ready`.
- **Simultaneous push and pop**: occupancy is unchanged and order is preserved.
- **FIFO**
  - Occupancy counter is `$clog2(pFIFO_DEPTH+1)` bits wide.
  - Read and write pointers wrap at `pFIFO_DEPTH` (a non-power-of-two depth wraps explicitly).
- **Reset values**
  - `word_out` = 0, `word_out_valid` = 0, `locked` = 0, `overflow` = 0.
  - Reset mid-word discards all state immediately, with no partial output.

## Timing
- Sync detect: suppose the last sync nibble is sampled at edge T.
  - `locked`=1 after edge T.
  - The first data nibble is sampled at edge T+1.
- Word completion: the 8th nibble is sampled at edge N.
  - The word is written at edge N.
  - `word_out`/`word_out_valid` reflect it after edge N, when the FIFO was empty. The path from FIFO storage to `word_out` is combinational; there is no extra register stage.
- Pop: the head advances at the edge where `valid`&&`ready`. The next entry (or `valid`=0) appears after that edge.
- Sustained throughput: one word per 8 valid beats. With `word_out_ready` held high, the FIFO never fills.
- `rxdata_in` is assumed synchronous to `coreclk`; the upstream receiver guarantees this.

## Configuration
- **`FSIC_RX_FRAMER_SYNC_FILTER_EN` defined**: in LOCKED, a completed word equal to `pSYNC_PATTERN` is treated as a keep-alive.
  - It is not pushed.
  - It does not set `overflow`.
  - The nibble count still wraps normally.
- **Not defined**: every completed word in LOCKED is pushed, including sync-pattern words.

## Test plan
- **Reset**
  - Stimulus: `axis_rst_n`=0, with `rxen`=1 and valid beats toggling.
  - Required: `word_out`=0, `word_out_valid`=0, `locked`=0, `overflow`=0. After release, the block enters HUNT within one edge.
- **Alignment**
  - Stimulus: garbage nibbles 3,3,3, then 5,A,3,C,A,5,C,F, then 8,7,6,5,4,3,2,1.
  - Required: `locked` rises after the F beat. `word_out`=32'h1234_5678 with `valid`=1 right after the "1" edge.
- **Backpressure / overflow** (`pFIFO_DEPTH`=4, `ready`=0)
  - Stimulus: send 5 words 0x0000_0001..0x0000_0005.
  - Required: `overflow`=1 after the 5th word. Then `ready`=1 pops 1,2,3,4 in order, then `valid`=0.
- **Full plus simultaneous pop**
  - Stimulus: FIFO full, `ready`=1 on the cycle a new word completes.
  - Required: `overflow` stays 0 and occupancy stays 4.
- **Loss of valid mid-word**
  - Stimulus: after 3 nibbles of a word, `rxdata_in_valid`=0 for 1 cycle.
  - Required: `locked`=0 next edge, no word pushed, and earlier FIFO words are still readable.
- **Sync filter**
  - Stimulus: while locked, send the sync word followed by 0xDEAD_BEEF.
  - Required with `FSIC_RX_FRAMER_SYNC_FILTER_EN`: only 0xDEAD_BEEF is output.
  - Required without it: 0xFC5A_C3A5, then 0xDEAD_BEEF.
  - Then drop `rxen`: `valid`=0, `overflow`=0 and state IDLE after one edge.
